// File: rtl/uop_dispatch_queue_if.sv
// Decode-to-issue handshake bundle for uop_dispatch_queue.
// The slave modport is the queue; the master modport is the decode/issue side.
interface uop_dispatch_queue_if #(
  parameter int UOP_WIDTH = 60
);
  logic                 in_valid;
  logic                 in_ready;
  logic [UOP_WIDTH-1:0] in_uop;
  logic                 in_nop;
  logic                 in_invalid;
  logic                 out_valid;
  logic                 out_ready;
  logic [UOP_WIDTH-1:0] out_uop;

  modport slave (
    input  in_valid, in_uop, in_nop, in_invalid, out_ready,
    output in_ready, out_valid, out_uop
  );

  modport master (
    output in_valid, in_uop, in_nop, in_invalid, out_ready,
    input  in_ready, out_valid, out_uop
  );
endinterface

// File: rtl/uop_dispatch_queue.sv
// In-order uop FIFO between decode and issue: drops nops, traps illegal uops into HALT.
// Optional macro UOP_DISPATCH_QUEUE_BYPASS_EN enables a 0-cycle empty-queue bypass.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | normal operation, accepting uops while not full
// ST_HALT | illegal uop seen; input blocked, entries still drain
module uop_dispatch_queue #(
  parameter int UOP_WIDTH = 60,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  uop_dispatch_queue_if.slave  bus,
  output logic                 illegal_instr,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [PTR_W-1:0]     PTR_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  logic [0:0]           state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic [UOP_WIDTH-1:0] mem_q [DEPTH];
  logic [UOP_WIDTH-1:0] mem_d [DEPTH];

  logic                 in_ready_c;
  logic                 accept;
  logic                 acc_invalid;
  logic                 acc_legal;
  logic                 byp_take;
  logic                 not_empty;
  logic                 enq;
  logic                 deq;
  logic                 out_valid_c;
  logic [UOP_WIDTH-1:0] out_uop_c;

  always_comb begin
    not_empty   = (count_q != '0);
    in_ready_c  = (state_q == ST_RUN) && (count_q < CNT_FULL);
    accept      = bus.in_valid && in_ready_c;
    acc_invalid = accept && bus.in_invalid;
    acc_legal   = accept && !bus.in_invalid && !bus.in_nop;
`ifdef UOP_DISPATCH_QUEUE_BYPASS_EN
    // Empty queue: present a legal input straight to issue in the same cycle.
    byp_take = bus.in_valid && !bus.in_invalid && !bus.in_nop &&
               !not_empty && (state_q == ST_RUN) && !flush;
`else
    byp_take = 1'b0;
`endif
    out_valid_c = not_empty || byp_take;
    if (byp_take) begin
      out_uop_c = bus.in_uop;
    end else if (not_empty) begin
      out_uop_c = mem_q[rd_ptr_q];
    end else begin
      out_uop_c = '0;
    end
    // A bypassed uop consumed this cycle never lands in the array.
    enq = acc_legal && !(byp_take && bus.out_ready);
    deq = not_empty && bus.out_ready;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    mem_d     = mem_q;
    if (flush) begin
      state_d  = ST_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (acc_invalid) begin
        illegal_d = 1'b1;
        state_d   = ST_HALT;
      end
      if (enq) begin
        mem_d[wr_ptr_q] = bus.in_uop;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_uop   = out_uop_c;
  assign illegal_instr = illegal_q;
  assign halted        = (state_q == ST_HALT);
  assign count         = count_q;
endmodule

// File: tb/tb_uop_dispatch_queue.sv
// Directed self-checking bench for uop_dispatch_queue (DEPTH=8, UOP_WIDTH=60).
module tb_uop_dispatch_queue;
  localparam int UW = 60;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          illegal_instr;
  logic          halted;
  logic [CW-1:0] count;

  int compared   = 0;
  int mismatched = 0;

  uop_dispatch_queue_if #(.UOP_WIDTH(UW)) bus ();

  uop_dispatch_queue #(.UOP_WIDTH(UW), .DEPTH(8), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .illegal_instr (illegal_instr),
    .halted        (halted),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_uop     = '0;
    bus.in_nop     = 1'b0;
    bus.in_invalid = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_uop", 64'(bus.out_uop), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_illegal", 64'(illegal_instr), 64'd0);

    // 1: three pushes then drain
    bus.in_valid = 1'b1;
    bus.in_uop = 60'h1; tick();
    bus.in_uop = 60'h2; tick();
    bus.in_uop = 60'h3; tick();
    bus.in_valid = 1'b0;
    check("t1_count", 64'(count), 64'd3);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    check("t1_pop0", 64'(bus.out_uop), 64'h1); tick();
    check("t1_pop1", 64'(bus.out_uop), 64'h2); tick();
    check("t1_pop2", 64'(bus.out_uop), 64'h3); tick();
    check("t1_empty_valid", 64'(bus.out_valid), 64'd0);
    check("t1_empty_uop", 64'(bus.out_uop), 64'd0);
    check("t1_empty_count", 64'(count), 64'd0);
    bus.out_ready = 1'b0;

    // 2: fill, full stall with dequeue, wrap order
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_uop = 60'(16 + i);
      tick();
    end
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_full_ready", 64'(bus.in_ready), 64'd0);
    bus.in_uop = 60'h9;
    bus.out_ready = 1'b1;
    tick();
    check("t2_after_deq_count", 64'(count), 64'd7);
    check("t2_after_deq_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("t2_refill_count", 64'(count), 64'd8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("t2_drain", 64'(bus.out_uop), 64'(17 + i));
      tick();
    end
    check("t2_drain_last", 64'(bus.out_uop), 64'h9);
    tick();
    check("t2_drained", 64'(count), 64'd0);
    bus.out_ready = 1'b0;

    // 3: nop dropped between two legal uops
    bus.in_valid = 1'b1;
    bus.in_uop = 60'hA; tick();
    bus.in_uop = 60'hEE; bus.in_nop = 1'b1; tick();
    bus.in_nop = 1'b0;
    bus.in_uop = 60'hB; tick();
    bus.in_valid = 1'b0;
    check("t3_count", 64'(count), 64'd2);
    bus.out_ready = 1'b1;
    check("t3_pop0", 64'(bus.out_uop), 64'hA); tick();
    check("t3_pop1", 64'(bus.out_uop), 64'hB); tick();
    check("t3_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // 4: illegal trap, drain while halted, flush recovery
    bus.in_valid = 1'b1;
    bus.in_uop = 60'hC; tick();
    bus.in_uop = 60'hDD; bus.in_invalid = 1'b1; bus.in_nop = 1'b1; tick();
    bus.in_invalid = 1'b0; bus.in_nop = 1'b0;
    bus.in_uop = 60'h77;
    check("t4_illegal_pulse", 64'(illegal_instr), 64'd1);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_in_ready", 64'(bus.in_ready), 64'd0);
    check("t4_count", 64'(count), 64'd1);
    bus.out_ready = 1'b1;
    check("t4_drain_c", 64'(bus.out_uop), 64'hC);
    tick();
    check("t4_illegal_clear", 64'(illegal_instr), 64'd0);
    check("t4_halt_drained", 64'(count), 64'd0);
    check("t4_still_halted", 64'(halted), 64'd1);
    bus.out_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_flush_halted", 64'(halted), 64'd0);
    check("t4_flush_ready", 64'(bus.in_ready), 64'd1);
    check("t4_flush_count", 64'(count), 64'd0);
    // flush beats an accepted illegal uop in the same cycle
    bus.in_valid = 1'b1; bus.in_invalid = 1'b1; flush = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_invalid = 1'b0; flush = 1'b0;
    check("t4_flush_supp_pulse", 64'(illegal_instr), 64'd0);
    check("t4_flush_supp_halt", 64'(halted), 64'd0);

    // 5: steady push/pop at count 4, then flush with input offered
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_uop = 60'(32 + i);
      tick();
    end
    check("t5_count_init", 64'(count), 64'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_uop = 60'(48 + k);
      check("t5_head", 64'(bus.out_uop), (k < 4) ? 64'(32 + k) : 64'(48 + k - 4));
      tick();
      check("t5_count", 64'(count), 64'd4);
    end
    check("t5_head_final", 64'(bus.out_uop), 64'h36);
    bus.out_ready = 1'b0;
    bus.in_uop = 60'h99;
    flush = 1'b1; tick(); flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_count", 64'(count), 64'd0);
    check("t5_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t5_flush_uop", 64'(bus.out_uop), 64'd0);

    // 6: empty-queue latency (bypass or registered)
    bus.in_valid = 1'b1; bus.in_uop = 60'h5; bus.out_ready = 1'b1;
    #1;
`ifdef UOP_DISPATCH_QUEUE_BYPASS_EN
    check("t6_byp_valid", 64'(bus.out_valid), 64'd1);
    check("t6_byp_uop", 64'(bus.out_uop), 64'h5);
    tick();
    bus.in_valid = 1'b0;
    check("t6_byp_count", 64'(count), 64'd0);
    check("t6_byp_after", 64'(bus.out_valid), 64'd0);
`else
    check("t6_same_cycle_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check("t6_next_valid", 64'(bus.out_valid), 64'd1);
    check("t6_next_uop", 64'(bus.out_uop), 64'h5);
    check("t6_next_count", 64'(count), 64'd1);
    tick();
    check("t6_consumed", 64'(count), 64'd0);
`endif
    bus.out_ready = 1'b0;

    // reset mid-operation discards contents
    bus.in_valid = 1'b1; bus.in_uop = 60'h42;
    tick(); tick();
    bus.in_valid = 1'b0;
    check("mid_rst_pre", 64'(count), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uop_dispatch_queue.md
Name: uop_dispatch_queue

Overview:
- Consumer side of the decode stage's output interface.
- Accepts one decoded uop per cycle with its nop/invalid flags under a valid/ready handshake, drops nops, and traps invalid instructions.
- Buffers legal uops in an in-order FIFO and presents them one per cycle to the issue/dispatch logic.
- Sits between decode and issue; flush input supports branch/exception recovery.

Parameters:
UOP_WIDTH, 60, width of the packed uop_t word
DEPTH, 8, FIFO entries; power of two, at least 2
CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all entries and clear halt; highest priority
in_valid  input  1  decode offers a uop this cycle
in_ready  output  1  queue can accept this cycle
in_uop  input  UOP_WIDTH  decoded uop (uop_t packed)
in_nop  input  1  decode flagged instruction as architectural nop
in_invalid  input  1  decode flagged instruction as illegal
out_valid  output  1  head entry available
out_ready  input  1  issue consumes head this cycle
out_uop  output  UOP_WIDTH  head uop; all-zero when out_valid=0
illegal_instr  output  1  one-cycle pulse, registered, on trap
halted  output  1  queue in HALT state
count  output  CNT_WIDTH  current occupancy

Behaviour:
- Reset (rst=1 at edge): pointers=0, count=0, state=RUN, illegal_instr=0. Outputs after reset: in_ready=1, out_valid=0, out_uop=0, halted=0, count=0. Reset mid-operation discards all contents.
- Clocking: one clock only; all registers reset synchronously.
- States:
  - RUN: normal operation.
  - HALT: entered on an accepted invalid uop; left only by flush or rst.
- in_ready = (state==RUN) && (count<DEPTH). It is not a function of out_ready, so there is no combinational path from output to input.
- Accept = in_valid && in_ready. On accept:
  - in_invalid=1: not enqueued. Next cycle illegal_instr=1 for exactly one cycle. State goes to HALT at the same edge. in_invalid has priority over in_nop.
  - in_nop=1, in_invalid=0: consumed and discarded. No enqueue, count unchanged.
  - Otherwise: in_uop is written at the write pointer, and the write pointer advances.
- Dequeue = out_valid && out_ready; the read pointer advances.
- out_valid = (count!=0) and is registered state; out_uop = mem[rd_ptr] when out_valid, else 0.
- Latency: an enqueued uop is visible on out_uop the cycle after accept (1 cycle, no bypass).
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance. When full, in_ready=0, so no enqueue occurs even if a dequeue happens in the same cycle.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- HALT: in_ready=0. Existing entries still drain through out_valid/out_ready.
- Flush: at the edge, pointers=0, count=0, state=RUN. Any same-cycle accept or dequeue is ignored, and a pending illegal_instr pulse is suppressed (illegal_instr=0 next cycle). Flush in the same cycle as rst behaves as rst.
- out_ready while out_valid=0: no effect.
- in_uop and the flags are don't-care when in_valid=0.

Optional Feature:
Macro: UOP_DISPATCH_QUEUE_BYPASS_EN
- Defined: when count==0, state==RUN and flush=0, a legal non-nop input is presented combinationally that cycle. out_valid=in_valid, out_uop=in_uop.
  - If out_ready=1 in that cycle, the uop is consumed without being written (0-cycle latency).
  - If out_ready=0, it is enqueued normally.
  - nop/invalid inputs never bypass.
  - This creates a combinational path from in_* to out_*.
- Undefined: strict 1-cycle latency as above; all outputs except in_ready/out_uop are registered.

Test Plan:
1. Reset, then push uops 0x1,0x2,0x3 on consecutive cycles with out_ready=0 -> count=3. Then out_ready=1 -> out_uop 0x1,0x2,0x3 on consecutive cycles, then out_valid=0, out_uop=0.
2. Fill DEPTH=8 entries -> in_ready=0 at count=8. Hold in_valid=1 with uop 0x9 plus one dequeue -> 0x9 is not taken that cycle, is accepted the next cycle, and pointer wrap preserves order.
3. Push uop with in_nop=1 between 0xA and 0xB -> queue holds only 0xA,0xB; count=2.
4. Push 0xC, then an in_invalid=1 uop -> illegal_instr=1 for one cycle, halted=1, in_ready=0. 0xC still drains. flush -> halted=0, in_ready=1, count=0.
5. Simultaneous push/pop at count=4 for 10 cycles -> count stays 4. Assert flush with in_valid=1 -> count=0 next cycle and the input is not stored.
6. With UOP_DISPATCH_QUEUE_BYPASS_EN: empty queue, in_uop=0x5, out_ready=1 -> out_valid=1, out_uop=0x5 in the same cycle, count stays 0. Without the macro -> appears the next cycle.
